// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait states
// One request at a time: IDLE accepts, BUSY counts down, RESP holds the result.
module dmem_responder #(
   parameter int MEM_BYTES   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [63:0] req_addr_i,
   input  logic [63:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [63:0] resp_rdata_o,
   output logic        resp_error_o
);

   localparam int          AW         = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
   localparam logic [63:0] LAST_LEGAL = 64'(MEM_BYTES - 8);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   state_t        r_state;
   logic [3:0]    r_count;
   logic          r_ready;
   logic          r_write;
   logic [63:0]   r_addr;
   logic [63:0]   r_wdata;
   logic          r_valid;
   logic [63:0]   r_rdata;
   logic          r_error;
   logic [7:0]    r_mem [MEM_BYTES];

   logic          w_err;
   logic          w_access;
   logic [AW-1:0] w_base;
   logic [63:0]   w_rd;

   // Full 64-bit compare so addresses near 2^64 cannot wrap into range.
   assign w_err    = (r_addr > LAST_LEGAL);
   assign w_base   = r_addr[AW-1:0];
   assign w_access = (r_state == S_BUSY) && (r_count == 4'd0);

   always_comb begin
      w_rd = '0;
      for (int i = 0; i < 8; i++) begin
         w_rd[8*i +: 8] = r_mem[w_base + AW'(i)];
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_access && r_write && !w_err) begin
         for (int i = 0; i < 8; i++) begin
            r_mem[w_base + AW'(i)] <= r_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_count <= 4'd0;
         r_ready <= 1'b1;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_valid <= 1'b0;
         r_rdata <= '0;
         r_error <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid_i) begin
                  r_write <= req_write_i;
                  r_addr  <= req_addr_i;
                  r_wdata <= req_wdata_i;
                  r_count <= 4'(WAIT_CYCLES);
                  r_ready <= 1'b0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_count != 4'd0) begin
                  r_count <= r_count - 4'd1;
               end else begin
                  r_valid <= 1'b1;
                  r_error <= w_err;
                  r_rdata <= (r_write || w_err) ? 64'd0 : w_rd;
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_ready_i) begin
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_ready <= 1'b1;
               r_valid <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready_o  = r_ready;
   assign resp_valid_o = r_valid;
   assign resp_rdata_o = r_rdata;
   assign resp_error_o = r_error;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
// Two instances: WAIT_CYCLES=2 for the main scenarios, WAIT_CYCLES=0 for spacing.
module tb_dmem_responder;

   localparam int MB = 1024;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   typedef struct {
      logic        w;
      logic [63:0] a;
      logic [63:0] d;
   } op_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        rv, rq, rw, sv, rr, se;
   logic [63:0] ra, wd, sd;
   logic        rv0, rq0, rw0, sv0, rr0, se0;
   logic [63:0] ra0, wd0, sd0;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] mdl [2][MB];
   exp_t q2[$];
   exp_t q0[$];

   dmem_responder #(.MEM_BYTES(MB), .WAIT_CYCLES(2)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(rv), .req_ready_o(rq), .req_write_i(rw),
      .req_addr_i(ra), .req_wdata_i(wd),
      .resp_valid_o(sv), .resp_ready_i(rr),
      .resp_rdata_o(sd), .resp_error_o(se)
   );

   dmem_responder #(.MEM_BYTES(MB), .WAIT_CYCLES(0)) dut0 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(rv0), .req_ready_o(rq0), .req_write_i(rw0),
      .req_addr_i(ra0), .req_wdata_i(wd0),
      .resp_valid_o(sv0), .resp_ready_i(rr0),
      .resp_rdata_o(sd0), .resp_error_o(se0)
   );

   // Reference behaviour: range check, little-endian byte array, zero data on writes/errors.
   function automatic exp_t model(input int m, input logic w, input logic [63:0] a,
                                  input logic [63:0] d, input int acc);
      exp_t e;
      e.err   = (a > 64'(MB - 8));
      e.rdata = '0;
      e.acc   = acc;
      if (!e.err) begin
         for (int i = 0; i < 8; i++) begin
            int idx;
            idx = int'(a[15:0]) + i;
            if (w) mdl[m][idx] = d[8*i +: 8];
            else   e.rdata[8*i +: 8] = mdl[m][idx];
         end
      end
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the response handshake.
   task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d, input string tag);
      exp_t e;
      int   cnt;
      rv = 1'b1; rw = w; ra = a; wd = d; rr = 1'b1;
      vectors++;
      if (rq !== 1'b1) begin
         miscompares++;
         $display("FAIL %s ready_idle: got %b expected 1", tag, rq);
      end
      q2.push_back(model(0, w, a, d, 0));
      @(negedge clk);
      rv = 1'b0; rw = ~w; ra = {$urandom, $urandom}; wd = {$urandom, $urandom};
      cnt = 1;
      while (sv !== 1'b1 && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      vectors++;
      if (cnt !== 4) begin
         miscompares++;
         $display("FAIL %s latency: got %0d expected 4 negedges", tag, cnt);
      end
      e = q2.pop_front();
      vectors++;
      if (sd !== e.rdata || se !== e.err) begin
         miscompares++;
         $display("FAIL %s resp: got rdata=%h err=%b expected rdata=%h err=%b",
                  tag, sd, se, e.rdata, e.err);
      end
      @(negedge clk);
      vectors++;
      if (sv !== 1'b0 || rq !== 1'b1) begin
         miscompares++;
         $display("FAIL %s handshake: got valid=%b ready=%b expected valid=0 ready=1", tag, sv, rq);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rv = 0; rw = 0; ra = '0; wd = '0; rr = 0;
      rv0 = 0; rw0 = 0; ra0 = '0; wd0 = '0; rr0 = 0;
      #12;
      vectors++;
      if (sv !== 1'b0 || sd !== 64'd0 || se !== 1'b0 || rq !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_state: got valid=%b rdata=%h err=%b ready=%b expected 0 0 0 1",
                  sv, sd, se, rq);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_write_read();
      xact(1'b1, 64'h10, 64'h1122334455667788, "write_10");
      xact(1'b1, 64'h18, 64'h99AABBCCDDEEFF00, "write_18");
      xact(1'b1, 64'h30, 64'h0F0E0D0C0B0A0908, "write_30");
      xact(1'b0, 64'h10, 64'd0, "read_10");
   endtask

   task automatic test_unaligned();
      exp_t e;
      xact(1'b0, 64'h11, 64'd0, "read_11");
      e = model(0, 1'b0, 64'h11, 64'd0, 0);
      vectors++;
      if (e.rdata !== 64'h0011223344556677) begin
         miscompares++;
         $display("FAIL unaligned_model: got %h expected 0011223344556677", e.rdata);
      end
      xact(1'b0, 64'h10, 64'd0, "reread_10");
   endtask

   task automatic test_boundary();
      xact(1'b1, 64'd1016, 64'hCAFEF00DDEADBEEF, "write_1016");
      xact(1'b0, 64'd1016, 64'd0, "read_1016");
      xact(1'b0, 64'd1017, 64'd0, "read_1017");
      xact(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "read_max");
      xact(1'b1, 64'd0, 64'h0102030405060708, "write_0");
      xact(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h5555555555555555, "write_wrap");
      xact(1'b0, 64'd0, 64'd0, "read_0");
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   cnt;
      rv = 1'b1; rw = 1'b0; ra = 64'h10; rr = 1'b0;
      q2.push_back(model(0, 1'b0, 64'h10, 64'd0, 0));
      @(negedge clk);
      rv = 1'b0;
      cnt = 1;
      while (sv !== 1'b1 && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      vectors++;
      if (cnt !== 4) begin
         miscompares++;
         $display("FAIL bp_latency: got %0d expected 4 negedges", cnt);
      end
      e = q2.pop_front();
      for (int k = 0; k < 5; k++) begin
         rv = 1'b1; rw = 1'b1; ra = 64'h30; wd = 64'hDEADDEADDEADDEAD;
         @(negedge clk);
         vectors++;
         if (sv !== 1'b1 || sd !== e.rdata || se !== e.err || rq !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got valid=%b rdata=%h err=%b ready=%b expected 1 %h %b 0",
                     k, sv, sd, se, rq, e.rdata, e.err);
         end
      end
      rv = 1'b0; rr = 1'b1;
      @(negedge clk);
      vectors++;
      if (sv !== 1'b0 || rq !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", sv, rq);
      end
      xact(1'b0, 64'h30, 64'd0, "bp_read_30");
   endtask

   task automatic test_reset_mid_write();
      xact(1'b1, 64'h20, 64'h7766554433221100, "pre_write_20");
      xact(1'b0, 64'h10, 64'd0, "pre_read_10");
      rv = 1'b1; rw = 1'b1; ra = 64'h20; wd = 64'hAAAAAAAAAAAAAAAA; rr = 1'b1;
      @(negedge clk);
      rv = 1'b0;
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (sv !== 1'b0 || sd !== 64'd0 || se !== 1'b0 || rq !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_reset: got valid=%b rdata=%h err=%b ready=%b expected 0 0 0 1",
                  sv, sd, se, rq);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      xact(1'b0, 64'h20, 64'd0, "post_reset_20");
   endtask

   task automatic test_back_to_back();
      op_t  ops[6];
      exp_t e;
      int   issued, got, last;
      logic chg;
      ops[0] = '{1'b1, 64'h40, 64'hA1A2A3A4A5A6A7A8};
      ops[1] = '{1'b1, 64'h48, 64'hB1B2B3B4B5B6B7B8};
      ops[2] = '{1'b0, 64'h40, 64'd0};
      ops[3] = '{1'b0, 64'h41, 64'd0};
      ops[4] = '{1'b0, 64'd1017, 64'd0};
      ops[5] = '{1'b0, 64'h48, 64'd0};
      issued = 0; got = 0; last = -1; chg = 1'b0;
      rr0 = 1'b1; rv0 = 1'b1;
      rw0 = ops[0].w; ra0 = ops[0].a; wd0 = ops[0].d;
      for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
         if (sv0 === 1'b1) begin
            vectors++;
            if (q0.size() == 0) begin
               miscompares++;
               $display("FAIL b2b_unexpected: got response %h with empty scoreboard", sd0);
            end else begin
               e = q0.pop_front();
               if (sd0 !== e.rdata || se0 !== e.err) begin
                  miscompares++;
                  $display("FAIL b2b_resp%0d: got rdata=%h err=%b expected rdata=%h err=%b",
                           got, sd0, se0, e.rdata, e.err);
               end
               vectors++;
               if (cyc - e.acc !== 2) begin
                  miscompares++;
                  $display("FAIL b2b_latency%0d: got %0d expected 2", got, cyc - e.acc);
               end
            end
            got++;
         end
         if (chg) begin
            chg = 1'b0;
            if (issued < 6) begin
               rw0 = ops[issued].w; ra0 = ops[issued].a; wd0 = ops[issued].d;
            end else begin
               rv0 = 1'b0;
            end
         end
         if (rv0 && rq0 === 1'b1) begin
            q0.push_back(model(1, rw0, ra0, wd0, cyc));
            if (last >= 0) begin
               vectors++;
               if (cyc - last !== 3) begin
                  miscompares++;
                  $display("FAIL b2b_spacing%0d: got %0d expected 3", issued, cyc - last);
               end
            end
            last = cyc;
            issued++;
            chg = 1'b1;
         end
         @(negedge clk);
      end
      vectors++;
      if (got !== 6) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d responses expected 6", got);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_unaligned();
      test_boundary();
      test_backpressure();
      test_reset_mid_write();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
